// File: rtl/inst_rom_responder.sv
// Instruction ROM responder: word-addressed storage with a side load port and a fixed-latency
// pipelined fetch path that classifies misaligned and out-of-range fetches as errors.
module inst_rom_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  fetch_err
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  logic                  w_pc_err;
  logic [DEPTH_LOG2-1:0] w_pc_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_ld_ok;
  logic [DEPTH_LOG2-1:0] w_ld_idx;

  assign w_pc_idx  = pc[DEPTH_LOG2+1:2];
  assign w_pc_err  = (pc[1:0] != 2'b00) || (|pc[ADDR_WIDTH-1:DEPTH_LOG2+2]);
  assign w_rd_word = w_pc_err ? '0 : r_mem[w_pc_idx];

  assign w_ld_idx = load_addr[DEPTH_LOG2+1:2];
  assign w_ld_ok  = load_en && (load_addr[1:0] == 2'b00) &&
                    !(|load_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]);

  // Storage is never reset; the read above samples the pre-write word (read-before-write).
  always_ff @(posedge clk) begin
    if (w_ld_ok) begin
      r_mem[w_ld_idx] <= load_data;
    end
  end

  logic                  w_out_vld;
  logic                  w_out_err;
  logic [DATA_WIDTH-1:0] w_out_word;
  logic [ADDR_WIDTH-1:0] w_out_addr;

  if (LATENCY <= 1) begin : g_direct
    assign w_out_vld  = ce;
    assign w_out_err  = w_pc_err;
    assign w_out_word = w_rd_word;
    assign w_out_addr = pc;
  end else begin : g_pipe
    localparam int unsigned Stages = LATENCY - 1;

    logic                  r_vld  [Stages];
    logic                  r_err  [Stages];
    logic [DATA_WIDTH-1:0] r_word [Stages];
    logic [ADDR_WIDTH-1:0] r_addr [Stages];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < Stages; i++) begin
          r_vld[i]  <= 1'b0;
          r_err[i]  <= 1'b0;
          r_word[i] <= '0;
          r_addr[i] <= '0;
        end
      end else begin
        r_vld[0]  <= ce;
        r_err[0]  <= ce && w_pc_err;
        r_word[0] <= w_rd_word;
        r_addr[0] <= pc;
        for (int unsigned i = 1; i < Stages; i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_err[i]  <= r_err[i-1];
          r_word[i] <= r_word[i-1];
          r_addr[i] <= r_addr[i-1];
        end
      end
    end

    assign w_out_vld  = r_vld[Stages-1];
    assign w_out_err  = r_err[Stages-1];
    assign w_out_word = r_word[Stages-1];
    assign w_out_addr = r_addr[Stages-1];
  end

  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_inst_valid;
  logic [ADDR_WIDTH-1:0] r_inst_addr;
  logic                  r_fetch_err;

  // Bubbles clear valid/err but leave the last word and address visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_inst_addr  <= '0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_inst_valid <= w_out_vld;
      r_fetch_err  <= w_out_vld && w_out_err;
      if (w_out_vld) begin
        r_inst      <= w_out_word;
        r_inst_addr <= w_out_addr;
      end
    end
  end

  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign inst_addr  = r_inst_addr;
  assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 2, 3) share one stimulus stream and are checked
// against a plain array model of storage plus per-instance expected-response queues.
module tb_inst_rom_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] pc = '0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic [31:0] inst_w  [3];
  logic        vld_w   [3];
  logic [31:0] addr_w  [3];
  logic        err_w   [3];

  always #5 clk = ~clk;

  inst_rom_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .inst(inst_w[0]), .inst_valid(vld_w[0]), .inst_addr(addr_w[0]),
    .fetch_err(err_w[0])
  );
  inst_rom_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .inst(inst_w[1]), .inst_valid(vld_w[1]), .inst_addr(addr_w[1]),
    .fetch_err(err_w[1])
  );
  inst_rom_responder #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .inst(inst_w[2]), .inst_valid(vld_w[2]), .inst_addr(addr_w[2]),
    .fetch_err(err_w[2])
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        err;
    int          issue;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  logic [31:0] mem_m [1024];
  logic [31:0] last_inst [3];
  logic [31:0] last_addr [3];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (LATENCY=%0d) at edge %0d: got %h, required %h", name, k + 1, cyc, act,
               req);
    end
  endtask

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: every valid response pops the next expected entry; bubbles must hold inst/addr.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        bit   ok;
        if (vld_w[k]) begin
          pop_exp(k, e, ok);
          if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp (LATENCY=%0d) at edge %0d: got pc %h, required none",
                     k + 1, cyc, addr_w[k]);
          end else begin
            check("inst", k, inst_w[k], e.word);
            check("inst_addr", k, addr_w[k], e.pc);
            check("fetch_err", k, 32'(err_w[k]), 32'(e.err));
            check("latency_edge", k, 32'(cyc), 32'(e.issue + k));
          end
          last_inst[k] = inst_w[k];
          last_addr[k] = addr_w[k];
        end else begin
          check("bubble_err", k, 32'(err_w[k]), 32'd0);
          check("bubble_inst_hold", k, inst_w[k], last_inst[k]);
          check("bubble_addr_hold", k, addr_w[k], last_addr[k]);
        end
      end
    end
  end

  // Drives one cycle of inputs (captured at the next edge) and updates the model.
  task automatic step(input bit c, input logic [31:0] p, input bit le, input logic [31:0] la,
                      input logic [31:0] ld);
    exp_t e;
    @(posedge clk);
    #2;
    ce = c;
    pc = p;
    load_en = le;
    load_addr = la;
    load_data = ld;
    if (c && !rst) begin
      e.pc    = p;
      e.err   = (p % 4 != 0) || (p >= 32'd4096);
      e.word  = e.err ? 32'd0 : mem_m[p / 4];
      e.issue = cyc + 1;
      q0.push_back(e);
      q1.push_back(e);
      q2.push_back(e);
    end
    if (le && (la % 4 == 0) && (la < 32'd4096)) mem_m[la / 4] = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) rand_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    else if (r == 7) rand_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
    else if (r == 8) rand_addr = $urandom | 32'h0000_1000;
    else rand_addr = 32'hFFFF_FFFC;
  endfunction

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 3) == 0),
           rand_addr(), $urandom);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      last_inst[k] = '0;
      last_addr[k] = '0;
    end
    // Fill storage while held in reset; fetches issued now must never respond.
    for (int i = 0; i < 1024; i++) step(1'b1, 32'(i * 4), 1'b1, 32'(i * 4), $urandom);
    step(1'b0, 32'd0, 1'b1, 32'h0, 32'h0000_0013);
    step(1'b0, 32'd0, 1'b1, 32'h4, 32'h0010_0093);
    step(1'b0, 32'd0, 1'b1, 32'h8, 32'h0020_0113);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_inst", k, inst_w[k], 32'd0);
      check("reset_valid", k, 32'(vld_w[k]), 32'd0);
      check("reset_addr", k, addr_w[k], 32'd0);
      check("reset_err", k, 32'(err_w[k]), 32'd0);
    end
    @(posedge clk);
    #2;
    load_en = 1'b0;
    rst = 1'b0;

    // Back-to-back fetches, single fetch, error classes, read-before-write, dropped load.
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 32'h4, 1'b0, 32'd0, 32'd0);
    step(1'b1, 32'h8, 1'b0, 32'd0, 32'd0);
    idle(4);
    step(1'b1, 32'h4, 1'b0, 32'd0, 32'd0);
    idle(4);
    step(1'b1, 32'h6, 1'b0, 32'd0, 32'd0);
    step(1'b1, 32'h0000_1000, 1'b0, 32'd0, 32'd0);
    idle(4);
    step(1'b1, 32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF);
    step(1'b1, 32'h8, 1'b0, 32'd0, 32'd0);
    idle(4);
    step(1'b0, 32'h0, 1'b1, 32'h2, 32'h1234_5678);
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0);
    idle(4);

    rand_phase(400);

    // Reset between edges with requests in flight; they must be lost.
    step(1'b0, 32'd0, 1'b1, 32'h0, 32'h0000_0013);
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 32'h4, 1'b0, 32'd0, 32'd0);
    step(1'b1, 32'h8, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    ce = 1'b0;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      check("async_reset_inst", k, inst_w[k], 32'd0);
      check("async_reset_valid", k, 32'(vld_w[k]), 32'd0);
      check("async_reset_addr", k, addr_w[k], 32'd0);
      last_inst[k] = '0;
      last_addr[k] = '0;
    end
    #5;
    rst = 1'b0;
    idle(3);
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0);
    idle(4);

    rand_phase(300);
    idle(6);

    n_checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d/%0d outstanding responses, required 0/0/0", q0.size(),
               q1.size(), q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
